// File: rtl/copr_stream_pkg.sv
// Shared defaults, derived widths and lane placement for the stream packer.
// Define COPR_PACKER_BIG_ENDIAN_EN to place the first beat of a word in the MSBs.
package copr_stream_pkg;

  localparam int unsigned IN_BYTES_DEF = 2;
  localparam int unsigned RATIO_DEF    = 2;
  localparam int unsigned LANE_W_DEF   = 8 * IN_BYTES_DEF;
  localparam int unsigned WORD_W_DEF   = LANE_W_DEF * RATIO_DEF;
  localparam int unsigned STRB_W_DEF   = IN_BYTES_DEF * RATIO_DEF;

  // What the output register is loaded with on the coming edge.
  typedef enum logic [1:0] {
    LoadNone,
    LoadFull,
    LoadFlush
  } load_e;

  function automatic int unsigned lane_w(input int unsigned in_bytes);
    return 8 * in_bytes;
  endfunction

  function automatic int unsigned word_w(input int unsigned in_bytes, input int unsigned ratio);
    return 8 * in_bytes * ratio;
  endfunction

  function automatic int unsigned strb_w(input int unsigned in_bytes, input int unsigned ratio);
    return in_bytes * ratio;
  endfunction

  // Bit-slot index inside the packed word for the k-th accepted lane.
  function automatic int unsigned lane_idx(input int unsigned k, input int unsigned ratio);
`ifdef COPR_PACKER_BIG_ENDIAN_EN
    return ratio - 1 - k;
`else
    return (k < ratio) ? k : 0;
`endif
  endfunction

endpackage

// File: rtl/copr_stream_out_reg.sv
// Output word register with valid/ready hold: loads a word, keeps it stable
// until the consumer takes it, and can reload in the same cycle it drains.
module copr_stream_out_reg
  import copr_stream_pkg::*;
#(
  parameter int unsigned DATA_W = WORD_W_DEF,
  parameter int unsigned STRB_W = STRB_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [STRB_W-1:0] load_strb,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [STRB_W-1:0] out_strb
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_strb  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_strb  <= load_strb;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // A stalled word must not change under the consumer.
  hold_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_strb)));

endmodule

// File: rtl/copr_stream_packer.sv
// Packs RATIO narrow input beats into one wide output word, with flush of partial words.
// Lane order follows COPR_PACKER_BIG_ENDIAN_EN (first beat in MSBs when defined).
module copr_stream_packer
  import copr_stream_pkg::*;
#(
  parameter int unsigned IN_BYTES = IN_BYTES_DEF,
  parameter int unsigned RATIO    = RATIO_DEF
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [8*IN_BYTES-1:0]       in_data,
  input  logic [IN_BYTES-1:0]         in_strb,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        flush_i,
  output logic [8*IN_BYTES*RATIO-1:0] out_data,
  output logic [IN_BYTES*RATIO-1:0]   out_strb,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        busy_o
);

  localparam int unsigned LANE_W = lane_w(IN_BYTES);
  localparam int unsigned WORD_W = word_w(IN_BYTES, RATIO);
  localparam int unsigned STRB_W = strb_w(IN_BYTES, RATIO);
  localparam int unsigned CNT_W  = $clog2(RATIO);
  localparam logic [CNT_W-1:0] LastLane = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                flush_pending_q, flush_pending_d;
  logic [LANE_W-1:0]   acc_data_q [RATIO-1];
  logic [IN_BYTES-1:0] acc_strb_q [RATIO-1];

  logic [LANE_W-1:0]   lane_data [RATIO];
  logic [IN_BYTES-1:0] lane_strb [RATIO];
  logic [WORD_W-1:0]   load_data;
  logic [STRB_W-1:0]   load_strb;
  load_e               load_kind;
  logic                out_free;
  logic                accept;

  // The last lane only blocks when the output register cannot take the word.
  always_comb begin
    out_free = !out_valid || out_ready;
    in_ready = !rst_i && !flush_pending_q && ((cnt_q != LastLane) || out_free);
    accept   = in_valid && in_ready;

    load_kind = LoadNone;
    if (accept && (cnt_q == LastLane)) begin
      load_kind = LoadFull;
    end else if (flush_pending_q && out_free) begin
      load_kind = LoadFlush;
    end
  end

  always_comb begin
    cnt_d           = cnt_q;
    flush_pending_d = flush_pending_q;
    unique case (load_kind)
      LoadFull: cnt_d = '0;
      LoadFlush: begin
        cnt_d           = '0;
        flush_pending_d = 1'b0;
      end
      default: begin
        if (accept) cnt_d = cnt_q + CNT_W'(1);
      end
    endcase
    // A beat that completes the word already emits it, so no extra partial word.
    if (flush_i && !flush_pending_q && ((cnt_q != '0) || accept) && (load_kind != LoadFull)) begin
      flush_pending_d = 1'b1;
    end
  end

  // Unfilled lanes read zero because the accumulator is cleared on every load.
  always_comb begin
    for (int unsigned k = 0; k < RATIO - 1; k++) begin
      lane_data[k] = acc_data_q[k];
      lane_strb[k] = acc_strb_q[k];
    end
    lane_data[RATIO-1] = (load_kind == LoadFull) ? in_data : '0;
    lane_strb[RATIO-1] = (load_kind == LoadFull) ? in_strb : '0;

    load_data = '0;
    load_strb = '0;
    for (int unsigned k = 0; k < RATIO; k++) begin
      load_data[lane_idx(k, RATIO)*LANE_W +: LANE_W]     = lane_data[k];
      load_strb[lane_idx(k, RATIO)*IN_BYTES +: IN_BYTES] = lane_strb[k];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q           <= '0;
      flush_pending_q <= 1'b0;
      for (int unsigned k = 0; k < RATIO - 1; k++) begin
        acc_data_q[k] <= '0;
        acc_strb_q[k] <= '0;
      end
    end else begin
      cnt_q           <= cnt_d;
      flush_pending_q <= flush_pending_d;
      for (int unsigned k = 0; k < RATIO - 1; k++) begin
        if (load_kind != LoadNone) begin
          acc_data_q[k] <= '0;
          acc_strb_q[k] <= '0;
        end else if (accept && (cnt_q == CNT_W'(k))) begin
          acc_data_q[k] <= in_data;
          acc_strb_q[k] <= in_strb;
        end
      end
    end
  end

  copr_stream_out_reg #(
    .DATA_W (WORD_W),
    .STRB_W (STRB_W)
  ) u_out_reg (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load      (load_kind != LoadNone),
    .load_data (load_data),
    .load_strb (load_strb),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_strb  (out_strb)
  );

  assign busy_o = (cnt_q != '0) || flush_pending_q || out_valid;

endmodule

// File: tb/tb_copr_stream_packer.sv
// Self-checking bench for copr_stream_packer: directed vector table, corner sequences,
// and randomized traffic against a beat-queue reference model.
module tb_copr_stream_packer;

  localparam int unsigned IB = 2;
  localparam int unsigned R  = 2;
  localparam int unsigned LW = 8 * IB;
  localparam int unsigned WW = LW * R;
  localparam int unsigned SW = IB * R;

`ifdef COPR_PACKER_BIG_ENDIAN_EN
  localparam logic [WW-1:0] W12  = 32'h1111_2222;
  localparam logic [WW-1:0] WAB  = 32'hABCD_0000;
  localparam logic [SW-1:0] SAB  = 4'hC;
  localparam logic [WW-1:0] W01  = 32'h0101_0202;
  localparam logic [WW-1:0] W78  = 32'h7777_8888;
`else
  localparam logic [WW-1:0] W12  = 32'h2222_1111;
  localparam logic [WW-1:0] WAB  = 32'h0000_ABCD;
  localparam logic [SW-1:0] SAB  = 4'h3;
  localparam logic [WW-1:0] W01  = 32'h0202_0101;
  localparam logic [WW-1:0] W78  = 32'h8888_7777;
`endif

  logic          clk = 1'b0;
  logic          rst_i;
  logic [LW-1:0] in_data;
  logic [IB-1:0] in_strb;
  logic          in_valid;
  logic          in_ready;
  logic          flush_i;
  logic [WW-1:0] out_data;
  logic [SW-1:0] out_strb;
  logic          out_valid;
  logic          out_ready;
  logic          busy_o;

  always #5 clk = ~clk;

  copr_stream_packer #(
    .IN_BYTES (IB),
    .RATIO    (R)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .in_data   (in_data),
    .in_strb   (in_strb),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush_i   (flush_i),
    .out_data  (out_data),
    .out_strb  (out_strb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy_o    (busy_o)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: beats waiting for a word, words waiting for the consumer.
  logic [LW-1:0] mbd [$];
  logic [IB-1:0] mbs [$];
  logic [WW-1:0] med [$];
  logic [SW-1:0] mes [$];
  bit            mfp = 1'b0;

  logic          s_in_ready, s_out_valid, s_busy;
  logic [WW-1:0] s_out_data;
  bit            s_acc;
  int            n_hs = 0;

  typedef struct {
    logic          v;
    logic [LW-1:0] d;
    logic          f;
    logic          e_rdy;
    logic          e_val;
    logic [WW-1:0] e_data;
    logic [SW-1:0] e_strb;
    logic          e_busy;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pos(input int k);
`ifdef COPR_PACKER_BIG_ENDIAN_EN
    return R - 1 - k;
`else
    return k;
`endif
  endfunction

  function automatic void push_word();
    logic [WW-1:0] w = '0;
    logic [SW-1:0] s = '0;
    for (int k = 0; k < mbd.size(); k++) begin
      w[pos(k)*LW +: LW] = mbd[k];
      s[pos(k)*IB +: IB] = mbs[k];
    end
    med.push_back(w);
    mes.push_back(s);
    mbd.delete();
    mbs.delete();
  endfunction

  // One clock cycle: drive, check against the model before the edge, advance the model.
  task automatic step(input logic v, input logic [LW-1:0] d, input logic [IB-1:0] s,
                      input logic f, input logic r, input logic rs);
    bit acc, ohs, free, fp_old, done, e_rdy;
    in_valid  = v;
    in_data   = d;
    in_strb   = s;
    flush_i   = f;
    out_ready = r;
    rst_i     = rs;
    @(negedge clk);
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    s_out_data  = out_data;
    s_busy      = busy_o;
    acc = v && in_ready;
    ohs = out_valid && r;
    e_rdy = !rs && !mfp && !((mbd.size() == R - 1) && (med.size() != 0) && !r);
    chk("in_ready", 64'(in_ready), 64'(e_rdy));
    chk("out_valid", 64'(out_valid), 64'(med.size() != 0));
    chk("busy", 64'(busy_o), 64'((mbd.size() != 0) || mfp || (med.size() != 0)));
    if (med.size() != 0) begin
      chk("out_data", 64'(out_data), 64'(med[0]));
      chk("out_strb", 64'(out_strb), 64'(mes[0]));
    end
    s_acc = acc;
    if (ohs) n_hs++;
    if (rs) begin
      mbd.delete(); mbs.delete(); med.delete(); mes.delete();
      mfp = 1'b0;
    end else begin
      free   = (med.size() == 0) || r;
      fp_old = mfp;
      done   = 1'b0;
      if (ohs && med.size() != 0) begin
        void'(med.pop_front());
        void'(mes.pop_front());
      end
      if (fp_old && free) begin
        push_word();
        mfp = 1'b0;
      end
      if (acc) begin
        mbd.push_back(d);
        mbs.push_back(s);
        if (mbd.size() == R) begin
          push_word();
          done = 1'b1;
        end
      end
      if (f && !fp_old && !done && mbd.size() != 0) mfp = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Each row: inputs for the cycle and the outputs expected during that cycle.
    tbl[0] = '{1'b1, 16'h1111, 1'b0, 1'b1, 1'b0, '0,  '0,   1'b0};
    tbl[1] = '{1'b1, 16'h2222, 1'b0, 1'b1, 1'b0, '0,  '0,   1'b1};
    tbl[2] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, W12, 4'hF, 1'b1};
    tbl[3] = '{1'b1, 16'hABCD, 1'b0, 1'b1, 1'b0, '0,  '0,   1'b0};
    tbl[4] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, '0,  '0,   1'b1};
    tbl[5] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, '0,  '0,   1'b1};
    tbl[6] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, WAB, SAB,  1'b1};
    tbl[7] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, '0,  '0,   1'b0};
    tbl[8] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, '0,  '0,   1'b0};

    rst_i = 1'b1; in_valid = 1'b0; in_data = '0; in_strb = '0; flush_i = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_out_strb", 64'(out_strb), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));

    for (int i = 0; i < 9; i++) begin
      step(tbl[i].v, tbl[i].d, 2'b11, tbl[i].f, 1'b1, 1'b0);
      chk($sformatf("vec%0d_rdy", i), 64'(s_in_ready), 64'(tbl[i].e_rdy));
      chk($sformatf("vec%0d_val", i), 64'(s_out_valid), 64'(tbl[i].e_val));
      chk($sformatf("vec%0d_busy", i), 64'(s_busy), 64'(tbl[i].e_busy));
      if (tbl[i].e_val) chk($sformatf("vec%0d_data", i), 64'(s_out_data), 64'(tbl[i].e_data));
    end

    // Full throughput: 8 beats back to back produce 4 words.
    n_hs = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, LW'(16'h1010 * (i + 1)), 2'b11, 1'b0, 1'b1, 1'b0);
      chk("thru_in_ready", 64'(s_in_ready), 64'(1));
    end
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    chk("thru_words", 64'(n_hs), 64'(4));

    // Consumer stalls: second word cannot complete, first word held.
    for (int b = 0; b < 3; b++) begin
      for (int t = 0; t < 8; t++) begin
        step(1'b1, LW'(16'h0101 * (b + 1)), 2'b11, 1'b0, 1'b0, 1'b0);
        if (s_acc) break;
      end
      chk("stall_accept", 64'(s_acc), 64'(1));
    end
    for (int t = 0; t < 3; t++) begin
      step(1'b1, 16'h0404, 2'b11, 1'b0, 1'b0, 1'b0);
      chk("stall_in_ready", 64'(s_in_ready), 64'(0));
      chk("stall_valid", 64'(s_out_valid), 64'(1));
      chk("stall_hold", 64'(s_out_data), 64'(W01));
    end
    step(1'b1, 16'h0404, 2'b11, 1'b0, 1'b1, 1'b0);
    chk("stall_release", 64'(s_acc), 64'(1));
    step(1'b1, 16'h0505, 2'b01, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    repeat (4) step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);

    // Reset mid-word discards the partial beat.
    step(1'b1, 16'h5555, 2'b11, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    chk("midrst_in_ready", 64'(s_in_ready), 64'(0));
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    chk("midrst_valid", 64'(s_out_valid), 64'(0));
    chk("midrst_busy", 64'(s_busy), 64'(0));
    step(1'b1, 16'h7777, 2'b11, 1'b0, 1'b1, 1'b0);
    step(1'b1, 16'h8888, 2'b11, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    chk("midrst_word_valid", 64'(s_out_valid), 64'(1));
    chk("midrst_word_data", 64'(s_out_data), 64'(W78));

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 9) < 7, LW'($urandom), IB'($urandom), $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) < 6, $urandom_range(0, 199) == 0);
    end

    step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    repeat (4) step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    chk("drain_valid", 64'(s_out_valid), 64'(0));
    chk("drain_busy", 64'(s_busy), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
